// File: rtl/cix32_prefetch_queue_if.sv
// Instruction-fetch memory bus between the prefetch queue and instruction memory.
interface cix32_prefetch_queue_if;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/cix32_prefetch_queue.sv
// Byte-granular instruction prefetch queue: fetches aligned 32-bit words into a
// circular byte buffer and presents up to four head bytes with their PC.
module cix32_prefetch_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [31:0]             flush_addr,
  cix32_prefetch_queue_if.master  mem,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic [31:0]             q_data,
  output logic [31:0]             q_pc,
  input  logic [2:0]              consume
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD,
    GAP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   next_addr;
  logic [31:0]   req_addr;
  logic [1:0]    skip;
  logic          armed;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [7:0]    buffer [DEPTH];
  logic          done;
  logic          accept;
  logic [CW-1:0] eff;
  logic [CW-1:0] fill;
  logic [31:0]   shifted;

  assign mem.mem_req  = (state == FETCH) || (state == DISCARD);
  // req_addr is latched at request launch so a flush during an outstanding
  // request moves only next_addr and the bus address stays stable.
  assign mem.mem_addr = req_addr;
  assign done         = mem.mem_req && mem.mem_ready;
  assign accept       = (state == FETCH) && done && !flush;
  assign shifted      = mem.mem_rdata >> {skip, 3'b000};
  assign fill         = accept ? CW'(3'd4 - {1'b0, skip}) : '0;

  // Clamp the consume request to the bytes actually present.
  always_comb begin
    eff = CW'(consume);
    if (CW'(consume) > q_count) begin
      eff = q_count;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the fetch handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!flush && armed && ((CW'(DEPTH) - q_count) >= CW'(4))) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (done) begin
          state_next = GAP;
        end else if (flush) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (done) begin
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Queue pointers, occupancy, PC and fetch-address bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= {RESET_PC[31:2], 2'b00};
      req_addr  <= {RESET_PC[31:2], 2'b00};
      skip      <= RESET_PC[1:0];
      armed     <= 1'b0;
      head      <= '0;
      tail      <= '0;
      q_count   <= '0;
      q_pc      <= RESET_PC;
    end else begin
      armed <= 1'b1;
      if (state == IDLE && state_next == FETCH) begin
        req_addr <= next_addr;
      end
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        q_count   <= '0;
        q_pc      <= flush_addr;
        next_addr <= {flush_addr[31:2], 2'b00};
        skip      <= flush_addr[1:0];
      end else begin
        head    <= head + eff[AW-1:0];
        tail    <= tail + fill[AW-1:0];
        q_count <= q_count - eff + fill;
        q_pc    <= q_pc + 32'(eff);
        if (accept) begin
          next_addr <= next_addr + 32'd4;
          skip      <= '0;
        end
      end
    end
  end

  // Byte storage: write the accepted bytes of the fetched word at the tail.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < 32'(fill)) begin
          buffer[tail + AW'(k)] <= shifted[8*k +: 8];
        end
      end
    end
  end

  // Head window: valid lanes from storage, empty lanes forced to zero.
  always_comb begin
    q_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (CW'(i) < q_count) begin
        q_data[8*i +: 8] = buffer[head + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_cix32_prefetch_queue.sv
// Self-checking bench for cix32_prefetch_queue: directed vector table, corner
// sequences, and randomized traffic against a byte-queue reference model.
module tb_cix32_prefetch_queue;

  localparam int unsigned DEPTH    = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   flush_addr = '0;
  logic [2:0]    consume = '0;
  logic [CW-1:0] q_count;
  logic [31:0]   q_data;
  logic [31:0]   q_pc;

  cix32_prefetch_queue_if bus ();

  cix32_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .flush_addr (flush_addr),
    .mem        (bus),
    .q_count    (q_count),
    .q_data     (q_data),
    .q_pc       (q_pc),
    .consume    (consume)
  );

  always #5 clk = ~clk;

  logic ready_reg;
  int   ready_mode = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_reg <= 1'b0;
    else        ready_reg <= bus.mem_req;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h40484040;
    if (a == 32'h4) return 32'h909090F4;
    return (a * 32'h9E3779B1) ^ 32'h5A3C96E1;
  endfunction

  // Reference model: the queue is a list of bytes; the bus is tracked only by
  // which request is in flight and whether its data must be thrown away.
  logic [7:0]  mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [1:0]  m_skip;
  bit          m_drop;
  bit          m_last_done;
  bit          m_armed;
  bit          m_exp_req;
  bit          m_prev_req;
  logic [31:0] m_prev_addr;

  task automatic model_reset();
    mq.delete();
    m_pc        = RESET_PC;
    m_fetch     = {RESET_PC[31:2], 2'b00};
    m_skip      = RESET_PC[1:0];
    m_drop      = 1'b0;
    m_last_done = 1'b0;
    m_armed     = 1'b0;
    m_exp_req   = 1'b0;
    m_prev_req  = 1'b0;
    m_prev_addr = '0;
  endtask

  task automatic step();
    logic        p_req, p_rdy, p_fl, done;
    logic [31:0] p_addr, p_fa, w, ed;
    int          eff, pre;
    bus.mem_ready = (ready_mode != 0) ? 1'($urandom_range(0, 2) != 0) : ready_reg;
    bus.mem_rdata = mem_word(bus.mem_addr);
    p_req  = bus.mem_req;
    p_rdy  = bus.mem_ready;
    p_fl   = flush;
    p_fa   = flush_addr;
    p_addr = bus.mem_addr;
    if (p_req && !m_drop) chk("mem_addr", p_addr, m_fetch);
    if (p_req && m_prev_req) chk("addr_stable", p_addr, m_prev_addr);
    pre  = mq.size();
    done = p_req && p_rdy;
    if (p_req && !done)                                  m_exp_req = 1'b1;
    else if (done || m_last_done || p_fl || !m_armed)    m_exp_req = 1'b0;
    else                                                 m_exp_req = (int'(DEPTH) - pre) >= 4;
    @(posedge clk);
    if (p_fl) begin
      mq.delete();
      m_pc    = p_fa;
      m_fetch = {p_fa[31:2], 2'b00};
      m_skip  = p_fa[1:0];
      m_drop  = p_req && !done;
    end else begin
      eff = (int'(consume) < pre) ? int'(consume) : pre;
      repeat (eff) void'(mq.pop_front());
      m_pc = m_pc + 32'(eff);
      if (done) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          w = mem_word(m_fetch);
          for (int k = int'(m_skip); k < 4; k++) mq.push_back(w[8*k +: 8]);
          m_fetch = m_fetch + 32'd4;
          m_skip  = '0;
        end
      end
    end
    m_prev_req  = p_req && !done;
    m_prev_addr = p_addr;
    m_last_done = done;
    m_armed     = 1'b1;
    @(negedge clk);
    ed = '0;
    for (int i = 0; i < 4; i++) if (i < mq.size()) ed[8*i +: 8] = mq[i];
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("q_pc", q_pc, m_pc);
    chk("q_data", q_data, ed);
    chk("mem_req", 32'(bus.mem_req), 32'(m_exp_req));
  endtask

  // Called at a negedge; asserts reset between edges and releases it likewise.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, {RESET_PC[31:2], 2'b00});
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_q_pc", q_pc, RESET_PC);
    chk("rst_q_data", q_data, 32'd0);
    model_reset();
    flush   = 1'b0;
    consume = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    int          cyc;
    logic [2:0]  cons;
    int          cnt;
    logic [31:0] pc;
    logic [31:0] data;
    logic        req;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  heads[$];
  logic [31:0] pcs[$];
  logic [7:0]  exp_heads[5];
  int          lowc;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    model_reset();

    tbl[0] = '{cyc: 0,  cons: 3'd0, cnt: 0,  pc: 32'h0, data: 32'h00000000, req: 1'b0};
    tbl[1] = '{cyc: 4,  cons: 3'd0, cnt: 4,  pc: 32'h0, data: 32'h40484040, req: 1'b0};
    tbl[2] = '{cyc: 4,  cons: 3'd0, cnt: 8,  pc: 32'h0, data: 32'h40484040, req: 1'b0};
    tbl[3] = '{cyc: 10, cons: 3'd0, cnt: 16, pc: 32'h0, data: 32'h40484040, req: 1'b0};
    tbl[4] = '{cyc: 1,  cons: 3'd4, cnt: 12, pc: 32'h4, data: 32'h909090F4, req: 1'b0};
    tbl[5] = '{cyc: 4,  cons: 3'd0, cnt: 16, pc: 32'h4, data: 32'h909090F4, req: 1'b0};
    exp_heads = '{8'h40, 8'h40, 8'h48, 8'h40, 8'hF4};

    // Fill to capacity, drain one word, refill (registered-ready memory).
    @(negedge clk);
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      consume = tbl[i].cons;
      repeat (tbl[i].cyc) step();
      chk($sformatf("tbl%0d_count", i), 32'(q_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_pc", i), q_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_data", i), q_data, tbl[i].data);
      chk($sformatf("tbl%0d_req", i), 32'(bus.mem_req), 32'(tbl[i].req));
    end
    consume = '0;

    // Single-byte consumption: bytes leave in order with no loss or repeat.
    @(negedge clk);
    pulse_reset();
    for (int n = 0; n < 40 && heads.size() < 5; n++) begin
      if (q_count != '0) begin
        heads.push_back(q_data[7:0]);
        pcs.push_back(q_pc);
        consume = 3'd1;
      end else begin
        consume = 3'd0;
      end
      step();
    end
    consume = '0;
    chk("seq_heads", 32'(heads.size()), 32'd5);
    for (int i = 0; i < heads.size() && i < 5; i++) begin
      chk($sformatf("seq_head%0d", i), 32'(heads[i]), 32'(exp_heads[i]));
      chk($sformatf("seq_pc%0d", i), pcs[i], 32'(i));
    end

    // Flush to a misaligned address while the first request is outstanding.
    step();
    pulse_reset();
    for (int n = 0; n < 10 && bus.mem_req !== 1'b1; n++) step();
    chk("fl_req_rise", 32'(bus.mem_req), 32'd1);
    chk("fl_addr0", bus.mem_addr, 32'h0);
    flush      = 1'b1;
    flush_addr = 32'h0000_0006;
    step();
    flush = 1'b0;
    chk("fl_count0", 32'(q_count), 32'd0);
    chk("fl_pc", q_pc, 32'h6);
    chk("fl_discard_req", 32'(bus.mem_req), 32'd1);
    for (int n = 0; n < 10 && bus.mem_req !== 1'b0; n++) step();
    for (int n = 0; n < 10 && bus.mem_req !== 1'b1; n++) step();
    chk("fl_refetch_req", 32'(bus.mem_req), 32'd1);
    chk("fl_refetch_addr", bus.mem_addr, 32'h4);
    for (int n = 0; n < 10 && q_count == '0; n++) step();
    chk("fl_count2", 32'(q_count), 32'd2);
    chk("fl_data", q_data, 32'h00009090);
    chk("fl_pc_hold", q_pc, 32'h6);
    consume = 3'd4;
    step();
    consume = 3'd0;
    chk("over_consume_count", 32'(q_count), 32'd0);
    chk("over_consume_pc", q_pc, 32'h8);

    // Reset asserted while a request is outstanding.
    for (int n = 0; n < 40 && !(q_count >= CW'(4) && bus.mem_req === 1'b1); n++) step();
    chk("mid_rst_req", 32'(bus.mem_req), 32'd1);
    pulse_reset();
    step();
    chk("rel1_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("rel2_req", 32'(bus.mem_req), 32'd1);
    chk("rel2_addr", bus.mem_addr, {RESET_PC[31:2], 2'b00});

    // Randomized traffic: random ready, consume, flushes (incl. near 2^32 wrap).
    ready_mode = 1;
    lowc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) lowc = $urandom_range(0, 1);
      if (lowc != 0) consume = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd0;
      else           consume = ($urandom_range(0, 9) < 3) ? 3'd0 : 3'($urandom_range(1, 4));
      case ($urandom_range(0, 29))
        0: begin flush = 1'b1; flush_addr = $urandom; end
        1: begin flush = 1'b1; flush_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)); end
        default: flush = 1'b0;
      endcase
      if ($urandom_range(0, 999) == 0) pulse_reset();
      step();
    end
    flush   = 1'b0;
    consume = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
